// File: rtl/lsu_byte_master_if.sv
// Byte-wide memory bus between the LSU (master) and data memory (slave).
// Latency: none, plain wires; one byte moves on each cycle with mem_req && mem_ack.
// Backpressure: memory stalls the master by holding mem_ack low, unbounded.
interface lsu_byte_master_if #(
  parameter int WIDTH = 32
) ();
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/lsu_byte_master.sv
// Serialises one word/half/byte load or store into byte transactions; sign/zero-extends loads.
// Latency: accept at T, bytes from T+1 (one per acked cycle), done one cycle after the last byte.
// Backpressure: busy stalls the pipeline; start while busy is dropped; mem_ack low holds the bus.
// Optional macro LSU_TRIGGER_MMIO_EN: loads from TRIGGER_ADDR return the trigger level with no bus traffic.
module lsu_byte_master #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] TRIGGER_ADDR = 32'h100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_is_store,
  input  logic [2:0]       i_modeAddr,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_WD,
  input  logic             i_trigger,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_RD,
  output logic             o_err,
  lsu_byte_master_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] M_WORD  = 3'b001;
  localparam logic [2:0] M_HALF  = 3'b010;
  localparam logic [2:0] M_BYTE  = 3'b011;
  localparam logic [2:0] M_HALFU = 3'b100;
  localparam logic [2:0] M_BYTEU = 3'b101;

  state_t           r_state;
  state_t           w_next;

  logic             r_is_store;
  logic [2:0]       r_mode;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wd;
  logic [WIDTH-1:0] r_buf;     // load byte lanes as they arrive
  logic [WIDTH-1:0] r_rd;      // last presented result, held between accesses
  logic [1:0]       r_k;       // index of the byte currently on the bus
  logic [1:0]       r_last;    // index of the final byte of this access
  logic             r_err;
  logic             r_trig;

  logic             w_accept;
  logic             w_legal_in;
  logic             w_trig_hit;
  logic [WIDTH-1:0] w_buf_init;
  logic             w_fire;
  logic             w_last_byte;
  logic [WIDTH-1:0] w_rd_ext;

  // Index of the last byte: word 3, half 1, byte 0. Stores share the mapping (size only).
  function automatic logic [1:0] f_last_idx(input logic [2:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    case (m)
      M_WORD:          idx = 2'd3;
      M_HALF, M_HALFU: idx = 2'd1;
      default:         idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign w_accept   = (r_state == S_IDLE) && i_start;
  assign w_legal_in = (i_modeAddr >= M_WORD) && (i_modeAddr <= M_BYTEU);

`ifdef LSU_TRIGGER_MMIO_EN
  // A legal load of the trigger address is answered locally from the trigger pin.
  assign w_trig_hit = !i_is_store && w_legal_in && (i_A == WIDTH'(TRIGGER_ADDR));
  assign w_buf_init = w_trig_hit ? {{(WIDTH-1){1'b0}}, i_trigger} : '0;
`else
  logic w_unused_trigger;
  assign w_unused_trigger = ^{i_trigger, TRIGGER_ADDR};
  assign w_trig_hit = 1'b0;
  assign w_buf_init = '0;
`endif

  assign w_fire      = (r_state == S_XFER) && mem.mem_ack;
  assign w_last_byte = w_fire && (r_k == r_last);

  // Load result formatting from the reassembled buffer.
  always_comb begin
    w_rd_ext = '0;
    if (r_trig) begin
      w_rd_ext = r_buf;
    end else begin
      case (r_mode)
        M_WORD:  w_rd_ext = r_buf;
        M_HALF:  w_rd_ext = {{(WIDTH-16){r_buf[15]}}, r_buf[15:0]};
        M_HALFU: w_rd_ext = {{(WIDTH-16){1'b0}}, r_buf[15:0]};
        M_BYTE:  w_rd_ext = {{(WIDTH-8){r_buf[7]}}, r_buf[7:0]};
        M_BYTEU: w_rd_ext = {{(WIDTH-8){1'b0}}, r_buf[7:0]};
        default: w_rd_ext = '0;
      endcase
    end
  end

  // Next-state and output decode; bus outputs are zero outside XFER.
  always_comb begin
    w_next        = r_state;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_err         = 1'b0;
    o_RD          = r_rd;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = (!w_legal_in || w_trig_hit) ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        o_busy        = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = r_is_store;
        mem.mem_addr  = r_addr + WIDTH'(r_k);
        mem.mem_wdata = r_wd[{r_k, 3'b000} +: 8];
        if (w_last_byte) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
        o_err  = r_err;
        if (r_err) begin
          o_RD = '0;
        end else if (!r_is_store) begin
          o_RD = w_rd_ext;
        end
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register, request capture, byte counter and load buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_store <= 1'b0;
      r_mode     <= '0;
      r_addr     <= '0;
      r_wd       <= '0;
      r_buf      <= '0;
      r_rd       <= '0;
      r_k        <= '0;
      r_last     <= '0;
      r_err      <= 1'b0;
      r_trig     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_is_store <= i_is_store;
        r_mode     <= i_modeAddr;
        r_addr     <= i_A;
        r_wd       <= i_WD;
        r_buf      <= w_buf_init;
        r_k        <= '0;
        r_last     <= f_last_idx(i_modeAddr);
        r_err      <= !w_legal_in;
        r_trig     <= w_trig_hit;
      end
      if (w_fire) begin
        if (!r_is_store) begin
          r_buf[{r_k, 3'b000} +: 8] <= mem.mem_rdata;
        end
        r_k <= r_k + 2'd1;
      end
      if (r_state == S_DONE) begin
        r_rd <= o_RD;
      end
    end
  end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Scoreboard bench: the issuer predicts byte transactions and results; a monitor checks them.
module tb_lsu_byte_master;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  modeAddr;
  logic [31:0] A;
  logic [31:0] WD;
  logic        trigger;
  logic        busy;
  logic        done;
  logic [31:0] RD;
  logic        err;

  lsu_byte_master_if #(.WIDTH(32)) bus ();

  lsu_byte_master #(.WIDTH(32), .TRIGGER_ADDR(32'h100)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (start),
    .i_is_store(is_store),
    .i_modeAddr(modeAddr),
    .i_A       (A),
    .i_WD      (WD),
    .i_trigger (trigger),
    .o_busy    (busy),
    .o_done    (done),
    .o_RD      (RD),
    .o_err     (err),
    .mem       (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } xfer_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } result_t;

  xfer_t       exp_x[$];
  result_t     exp_d[$];
  logic [7:0]  mem_arr [logic [31:0]];
  int          vectors = 0;
  int          miscompares = 0;
  int          nbytes = 0;
  int          ndone = 0;
  int          ack_mode = 1;  // 0 random, 1 always, 2 never, 3 three waits per byte
  int          wcnt = 0;
  logic [31:0] last_rd = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: ack pattern and read data, changed just after each rising edge.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0: bus.mem_ack = ($urandom_range(0, 99) < 60);
        1: bus.mem_ack = 1'b1;
        2: bus.mem_ack = 1'b0;
        default: begin
          if (bus.mem_req) begin
            if (wcnt == 3) begin
              bus.mem_ack = 1'b1;
              wcnt = 0;
            end else begin
              bus.mem_ack = 1'b0;
              wcnt++;
            end
          end else begin
            bus.mem_ack = 1'b0;
          end
        end
      endcase
      bus.mem_rdata = mem_rd(bus.mem_addr);
    end
  end

  // Monitor: byte transactions, bus stability under wait states, completions.
  initial begin
    logic        prev_wait;
    logic [31:0] pa;
    logic        pwe;
    logic [7:0]  pwd;
    xfer_t       x;
    result_t     r;
    prev_wait = 1'b0;
    pa = '0; pwe = 1'b0; pwd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          chk("req_held", {31'b0, bus.mem_req}, 32'h1);
          chk("addr_stable", bus.mem_addr, pa);
          chk("we_stable", {31'b0, bus.mem_we}, {31'b0, pwe});
          chk("wdata_stable", {24'b0, bus.mem_wdata}, {24'b0, pwd});
        end
        if (bus.mem_req && bus.mem_ack) begin
          if (exp_x.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte: got addr %h we %b, required no transaction",
                     bus.mem_addr, bus.mem_we);
          end else begin
            x = exp_x.pop_front();
            chk("byte_addr", bus.mem_addr, x.addr);
            chk("byte_we", {31'b0, bus.mem_we}, {31'b0, x.we});
            if (x.we) chk("byte_wdata", {24'b0, bus.mem_wdata}, {24'b0, x.wdata});
          end
          if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
          nbytes++;
        end
        prev_wait = bus.mem_req && !bus.mem_ack;
        pa  = bus.mem_addr;
        pwe = bus.mem_we;
        pwd = bus.mem_wdata;
        if (done) begin
          ndone++;
          if (exp_d.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got RD %h err %b, required no completion", RD, err);
          end else begin
            r = exp_d.pop_front();
            chk("done_rd", RD, r.rd);
            chk("done_err", {31'b0, err}, {31'b0, r.err});
          end
        end else if (err) begin
          vectors++;
          miscompares++;
          $display("FAIL err_without_done: got err 1, required 0");
        end
      end
    end
  end

  // Predict the access from the mode/size rules, then drive it and wait for completion.
  task automatic issue(input logic st, input logic [2:0] md, input logic [31:0] a,
                       input logic [31:0] wd, input logic trig, input bit inject);
    int          n;
    int          cyc;
    logic        legal;
    logic        th;
    logic [31:0] val;
    logic [31:0] rd;
    xfer_t       x;
    result_t     r;
    legal = (md >= 3'd1) && (md <= 3'd5);
    n = (md == 3'd1) ? 4 : ((md == 3'd2 || md == 3'd4) ? 2 : 1);
    th = 1'b0;
`ifdef LSU_TRIGGER_MMIO_EN
    th = !st && legal && (a == 32'h100);
`endif
    val = 32'h0;
    if (!legal) begin
      n = 0;
      rd = 32'h0;
    end else if (th) begin
      n = 0;
      rd = {31'b0, trig};
    end else begin
      for (int k = 0; k < n; k++) begin
        x.addr  = a + 32'(k);
        x.we    = st;
        x.wdata = 8'(wd >> (8 * k));
        exp_x.push_back(x);
        val = val | (32'(mem_rd(a + 32'(k))) << (8 * k));
      end
      if (st) rd = last_rd;
      else begin
        case (md)
          3'd1: rd = val;
          3'd2: rd = 32'($signed(val[15:0]));
          3'd3: rd = 32'($signed(val[7:0]));
          3'd4: rd = {16'h0, val[15:0]};
          default: rd = {24'h0, val[7:0]};
        endcase
      end
    end
    r.rd  = rd;
    r.err = !legal;
    exp_d.push_back(r);
    last_rd = rd;

    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) chk("idle_timeout", {31'b0, busy}, 32'h0);
    start = 1'b1; is_store = st; modeAddr = md; A = a; WD = wd; trigger = trig;
    @(negedge clk);
    chk("busy_after_accept", {31'b0, busy}, 32'h1);
    if (inject) begin
      start = 1'b1; is_store = 1'b1; modeAddr = 3'd1; A = 32'h500; WD = $urandom;
    end else begin
      start = 1'b0;
    end
    cyc = 1;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (!done) chk("done_timeout", {31'b0, done}, 32'h1);
    if (ack_mode == 1) chk("latency", 32'(cyc), 32'(n + 1));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", {31'b0, busy}, 32'h0);
    chk("done_single", {31'b0, done}, 32'h0);
  endtask

  initial begin
    int          b0;
    int          d0;
    logic [31:0] a;
    logic [2:0]  md;
    xfer_t       x;
    start = 1'b0; is_store = 1'b0; modeAddr = 3'd0; A = '0; WD = '0; trigger = 1'b0;
    rst = 1'b1;
    ack_mode = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_rd", RD, 32'h0);
    chk("rst_req", {31'b0, bus.mem_req}, 32'h0);
    chk("rst_we", {31'b0, bus.mem_we}, 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_wdata", {24'b0, bus.mem_wdata}, 32'h0);
    rst = 1'b0;

    // Word store, zero-wait memory.
    issue(1'b1, 3'd1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("mem10", {24'b0, mem_rd(32'h10)}, 32'hEF);
    chk("mem11", {24'b0, mem_rd(32'h11)}, 32'hBE);
    chk("mem12", {24'b0, mem_rd(32'h12)}, 32'hAD);
    chk("mem13", {24'b0, mem_rd(32'h13)}, 32'hDE);

    // Signed and unsigned byte loads.
    mem_arr[32'h20] = 8'h80;
    issue(1'b0, 3'd3, 32'h20, 32'h0, 1'b0, 1'b0);
    chk("lb_rd", RD, 32'hFFFFFF80);
    issue(1'b0, 3'd5, 32'h20, 32'h0, 1'b0, 1'b0);
    chk("lbu_rd", RD, 32'h00000080);

    // Misaligned half load with three wait cycles per byte.
    mem_arr[32'h31] = 8'h34;
    mem_arr[32'h32] = 8'h12;
    ack_mode = 3;
    wcnt = 0;
    d0 = ndone;
    issue(1'b0, 3'd2, 32'h31, 32'h0, 1'b0, 1'b0);
    chk("lh_rd", RD, 32'h00001234);
    chk("lh_done_count", 32'(ndone - d0), 32'h1);

    // Illegal mode, with a start attempted while busy.
    ack_mode = 1;
    b0 = nbytes;
    issue(1'b0, 3'd7, 32'h40, 32'h0, 1'b0, 1'b1);
    chk("illegal_rd", RD, 32'h0);
    chk("illegal_bytes", 32'(nbytes - b0), 32'h0);

    // Reset after two bytes of a word store.
    b0 = nbytes;
    d0 = ndone;
    x.addr = 32'h60; x.we = 1'b1; x.wdata = 8'h44; exp_x.push_back(x);
    x.addr = 32'h61; x.we = 1'b1; x.wdata = 8'h33; exp_x.push_back(x);
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; modeAddr = 3'd1; A = 32'h60; WD = 32'h11223344;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    ack_mode = 2;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_req", {31'b0, bus.mem_req}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_rd", RD, 32'h0);
    chk("abort_bytes", 32'(nbytes - b0), 32'h2);
    chk("abort_no_done", 32'(ndone - d0), 32'h0);
    chk("abort_mem62", {31'b0, mem_arr.exists(32'h62)}, 32'h0);
    rst = 1'b0;
    last_rd = 32'h0;
    ack_mode = 0;

    // Word load across the top of the address space.
    issue(1'b0, 3'd1, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0);

    // Trigger address.
    ack_mode = 1;
    b0 = nbytes;
    issue(1'b0, 3'd1, 32'h100, 32'h0, 1'b1, 1'b0);
`ifdef LSU_TRIGGER_MMIO_EN
    chk("trig_rd", RD, 32'h1);
    chk("trig_bytes", 32'(nbytes - b0), 32'h0);
`else
    chk("trig_bytes", 32'(nbytes - b0), 32'h4);
`endif

    // Randomised traffic.
    ack_mode = 0;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = 32'h100;
        2: a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        default: a = 32'h80 + 32'($urandom_range(0, 31));
      endcase
      md = 3'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), md, a, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    chk("exp_bytes_left", 32'(exp_x.size()), 32'h0);
    chk("exp_done_left", 32'(exp_d.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_byte_master.md
Name: lsu_byte_master

Overview:
- Load/store initiator on the requesting side of the byte-addressed data memory.
- Accepts one load or store from the pipeline MEM stage and serialises it into 1, 2 or 4 byte transactions over a req/ack byte bus toward memory.
- For loads, reassembles the bytes and applies sign or zero extension.
- Holds busy high while the access is in flight so the hazard unit can stall the pipeline.

Parameters:
- WIDTH, 32, data and address width. Only 32 is supported.
- TRIGGER_ADDR, 32'h100, MMIO trigger address. Used only when LSU_TRIGGER_MMIO_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe from pipeline; accepted only when busy=0.
- is_store  in  1  1=store, 0=load; sampled with start.
- modeAddr  in  3  access mode: 001 word, 010 half, 011 byte, 100 unsigned half, 101 unsigned byte. Stores use the size only (100 acts as 010, 101 acts as 011).
- A  in  WIDTH  byte address; sampled with start.
- WD  in  WIDTH  store data; sampled with start.
- trigger  in  1  external trigger level; read only under LSU_TRIGGER_MMIO_EN.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- RD  out  WIDTH  load result; valid in the done cycle and held until the next accepted start.
- err  out  1  one-cycle pulse coincident with done when modeAddr is illegal.
- mem_req  out  1  byte transaction request.
- mem_we  out  1  byte write enable; qualified by mem_req.
- mem_addr  out  WIDTH  byte address.
- mem_wdata  out  8  store byte.
- mem_rdata  in  8  load byte; sampled when mem_req && mem_ack.
- mem_ack  in  1  memory accepts or returns the current byte this cycle.

Behaviour:
- Reset values: busy=0, done=0, err=0, RD=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. State=IDLE, byte counter=0.
- Reset is synchronous. Asserted mid-access, it aborts the access at that edge. No done pulse and no further byte transactions follow; partially written bytes stay in memory.
- States: IDLE, XFER, DONE.
- IDLE:
  - On start=1, latch is_store, modeAddr, A, WD. Set byte count N (4 for word, 2 for half modes, 1 for byte modes) and counter k=0.
  - Legal mode: go to XFER.
  - Illegal mode (000, 110, 111): go to DONE with err pending, RD=0, and no memory transaction.
- XFER:
  - mem_req=1, mem_addr=A_latched+k with 32-bit wrap-around (FFFF_FFFF+1 = 0000_0000), mem_we=is_store.
  - mem_wdata = WD byte k, little-endian: k=0 gives WD[7:0], k=3 gives WD[31:24].
  - Outputs stay stable while mem_ack=0; wait states are unbounded.
  - On mem_req&&mem_ack: a load captures mem_rdata into byte lane k of an internal buffer; then k increments.
  - When the final byte (k=N-1) is acked, go to DONE. mem_req may stay high across consecutive bytes.
- DONE (one cycle):
  - done=1, busy=1, mem_req=0.
  - RD for loads: 001 = full word; 010 = sign-extended bits [15:0]; 100 = zero-extended bits [15:0]; 011 = sign-extended bits [7:0]; 101 = zero-extended bits [7:0].
  - RD for stores is unchanged from its previous value.
  - Next state is IDLE.
- Latency with zero-wait memory (ack tied high): start accepted at edge T; byte transactions at cycles T+1..T+N; done at T+N+1. busy is high T+1..T+N+1. The next start is accepted at T+N+2.
- start while busy=1 is ignored; there is no queue.
- Misaligned addresses are legal; bytes are simply issued at consecutive addresses.
- mem_ack while mem_req=0 is ignored.

Optional Feature:
- Macro: LSU_TRIGGER_MMIO_EN.
- Defined:
  - A legal load with A==TRIGGER_ADDR bypasses XFER. IDLE goes straight to DONE, RD={31'b0, trigger}, with trigger sampled at the accept edge and modeAddr ignored. No mem_req is issued.
  - A store to TRIGGER_ADDR proceeds to memory normally.
- Undefined: trigger is unused, and address 0x100 behaves like any other address.

Test Plan:
- Word store: A=0x10, WD=0xDEADBEEF, ack tied 1 -> bytes EF,BE,AD,DE written to 0x10..0x13 in cycles T+1..T+4; done at T+5, err=0.
- Signed byte load: memory[0x20]=0x80, modeAddr=011 -> RD=0xFFFFFF80. Same load with modeAddr=101 -> RD=0x00000080.
- Wait states on a half load from 0x31 (mem[0x31]=0x34, mem[0x32]=0x12): ack low 3 cycles per byte -> mem_addr/mem_req held stable while ack low; RD=0x00001234; done exactly once.
- Illegal mode 111 -> no mem_req asserted, done and err pulse together one cycle after accept, RD=0. start asserted while busy=1 is ignored.
- Reset after 2 of 4 word-store bytes -> mem_req=0 and busy=0 on the next cycle, only 2 bytes written, no done. Then a word load from 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- With LSU_TRIGGER_MMIO_EN: trigger=1, load from 0x100 -> RD=0x00000001, done at T+1, no mem_req. Without the macro, the same access issues 4 memory bytes.
